// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory controller arbitrating the MEM-stage byte port
// and the IF-stage word-fetch port onto one single-port synchronous byte RAM.
// Data requests beat fetch requests in IDLE; a fetch in flight is never
// preempted but is abandoned as soon as i_req is seen low.
//
// Request/response handshake: d_req and i_req are levels sampled only while
// the controller is IDLE. Completion is a one-cycle d_done or i_done pulse,
// during which the controller is IDLE again. The requester must update or
// drop its request within that done cycle, because the next request is
// sampled at the following rising edge.
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [31:0]       d_addr,
   input  logic [7:0]        d_wdata,
   output logic [7:0]        d_rdata,
   output logic              d_done,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [31:0]       i_inst,
   output logic              i_done,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      D_ISSUE = 3'd1,
      D_CAPT  = 3'd2,
      D_WR    = 3'd3,
      I_FETCH = 3'd4
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ram_a_q;
   logic [7:0]        ram_dout_q;
   logic              ram_wr_q;
   logic [7:0]        d_rdata_q;
   logic              d_done_q;
   logic [31:0]       i_inst_q;
   logic              i_done_q;
   logic [ADDR_W-1:0] base_q;
   logic [2:0]        issue_cnt_q;
   logic [2:0]        cap_cnt_q;
   logic [23:0]       inst_buf_q;

   // Next fetch byte address; the sum wraps modulo 2^ADDR_W.
   logic [ADDR_W-1:0] fetch_addr_d;
   assign fetch_addr_d = base_q + ADDR_W'(issue_cnt_q);

   // Address bits above the RAM width are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{d_addr[31:ADDR_W], i_addr[31:ADDR_W]};

   // Controller FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         d_rdata_q   <= '0;
         d_done_q    <= 1'b0;
         i_inst_q    <= '0;
         i_done_q    <= 1'b0;
         base_q      <= '0;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         inst_buf_q  <= '0;
      end else begin
         // Pulses and the write strobe fall back to 0 unless re-armed below.
         d_done_q <= 1'b0;
         i_done_q <= 1'b0;
         ram_wr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_req) begin
                  ram_a_q <= d_addr[ADDR_W-1:0];
                  if (d_rw) begin
                     ram_dout_q <= d_wdata;
                     ram_wr_q   <= 1'b1;
                     state_q    <= D_WR;
                  end else begin
                     state_q <= D_ISSUE;
                  end
               end else if (i_req) begin
                  // Byte 0 is issued at the sampling edge itself.
                  ram_a_q     <= i_addr[ADDR_W-1:0];
                  base_q      <= i_addr[ADDR_W-1:0];
                  issue_cnt_q <= 3'd1;
                  cap_cnt_q   <= 3'd0;
                  state_q     <= I_FETCH;
               end
            end
            D_ISSUE: begin
               // RAM samples the address at this edge.
               state_q <= D_CAPT;
            end
            D_CAPT: begin
               d_rdata_q <= ram_din;
               d_done_q  <= 1'b1;
               state_q   <= IDLE;
            end
            D_WR: begin
               d_done_q <= 1'b1;
               state_q  <= IDLE;
            end
            I_FETCH: begin
               if (!i_req) begin
                  // Abort: in-flight bytes are dropped, i_inst untouched.
                  state_q <= IDLE;
               end else begin
                  if (issue_cnt_q <= 3'd3) begin
                     ram_a_q <= fetch_addr_d;
                  end
                  issue_cnt_q <= issue_cnt_q + 3'd1;
                  // Read data trails its address by two edges.
                  if (issue_cnt_q >= 3'd2) begin
                     cap_cnt_q <= cap_cnt_q + 3'd1;
                     case (cap_cnt_q)
                        3'd0:    inst_buf_q[7:0]   <= ram_din;
                        3'd1:    inst_buf_q[15:8]  <= ram_din;
                        3'd2:    inst_buf_q[23:16] <= ram_din;
                        default: begin
                           i_inst_q <= {ram_din, inst_buf_q};
                           i_done_q <= 1'b1;
                           state_q  <= IDLE;
                        end
                     endcase
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ram_a    = ram_a_q;
   assign ram_dout = ram_dout_q;
   assign ram_wr   = ram_wr_q;
   assign d_rdata  = d_rdata_q;
   assign d_done   = d_done_q;
   assign i_inst   = i_inst_q;
   assign i_done   = i_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural byte RAM, table of
// read/write/fetch vectors, scoreboard queue popped on done pulses, and
// hand-written cycle-level sequences for timing and corner cases.
module tb_mem_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_req;
  logic              d_rw;
  logic [31:0]       d_addr;
  logic [7:0]        d_wdata;
  logic [7:0]        d_rdata;
  logic              d_done;
  logic              i_req;
  logic [31:0]       i_addr;
  logic [31:0]       i_inst;
  logic              i_done;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_req    (d_req),
    .d_rw     (d_rw),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_inst   (i_inst),
    .i_done   (i_done),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  // Synchronous byte RAM: samples address/write at the edge, read data
  // visible during the following cycle.
  logic [7:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [7:0] ram_rd_q;
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_rd_q <= ram_mem[ram_a];
  end
  assign ram_din = ram_rd_q;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  // {kind[1:0], data[31:0]}; kind 0 = read, 1 = write, 2 = fetch
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  logic [1:0]  mon_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (d_done || i_done)) begin
      if (d_done && i_done) begin
        check("done_overlap", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_k = mon_e[33:32];
        if (d_done) begin
          check("d_done_kind", {31'd0, mon_k == 2'd2}, 32'd0);
          if (mon_k == 2'd0) check("d_rdata", {24'd0, d_rdata}, mon_e[31:0]);
        end else begin
          check("i_done_kind", {30'd0, mon_k}, 32'd2);
          check("i_inst", i_inst, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] k, input logic [31:0] a,
                                  input logic [7:0] w, input logic [31:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.wdata = w; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic int lat_of(input logic [1:0] k);
    if (k == 2'd0) return 3;
    if (k == 2'd1) return 2;
    return 6;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [1:0] k, input logic [31:0] a,
                        input logic [7:0] w, input logic [31:0] e);
    int lat;
    bit seen;
    @(negedge clk);
    if (k == 2'd2) begin
      i_req = 1'b1; i_addr = a;
    end else begin
      d_req = 1'b1; d_rw = (k == 2'd1); d_addr = a; d_wdata = w;
    end
    exp_q.push_back({k, e});
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if ((k == 2'd2) ? i_done : d_done) seen = 1'b1;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    if (!seen) begin
      check("op_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      check("op_latency", lat, lat_of(k));
    end
  endtask

  // Fetch with per-cycle checks of the issued address and done timing.
  task automatic fetch_trace(input logic [31:0] a, input logic [31:0] e);
    logic [ADDR_W-1:0] exp_a;
    @(negedge clk);
    i_req = 1'b1; i_addr = a;
    exp_q.push_back({2'd2, e});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        exp_a = a[ADDR_W-1:0] + ADDR_W'(k);
        check("fetch_ram_a", {15'd0, ram_a}, {15'd0, exp_a});
      end
      check("fetch_ram_wr", {31'd0, ram_wr}, 32'd0);
      check("fetch_i_done", {31'd0, i_done}, {31'd0, k == 5});
    end
    i_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r_addr;
  logic [7:0]  r_b1;
  logic [7:0]  r_b2;

  initial begin
    rst = 1'b1; d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_addr = '0;
    repeat (2) @(negedge clk);
    check("rst0_ram_wr",  {31'd0, ram_wr}, 32'd0);
    check("rst0_d_done",  {31'd0, d_done}, 32'd0);
    check("rst0_i_done",  {31'd0, i_done}, 32'd0);
    check("rst0_ram_a",   {15'd0, ram_a}, 32'd0);
    check("rst0_d_rdata", {24'd0, d_rdata}, 32'd0);
    check("rst0_i_inst",  i_inst, 32'd0);
    rst = 1'b0;

    // Write with cycle-level checks.
    @(negedge clk);
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0000_0104; d_wdata = 8'hA5;
    exp_q.push_back({2'd1, 32'd0});
    @(negedge clk);
    check("wr_e0_ram_wr",   {31'd0, ram_wr}, 32'd1);
    check("wr_e0_ram_a",    {15'd0, ram_a}, 32'h104);
    check("wr_e0_ram_dout", {24'd0, ram_dout}, 32'hA5);
    check("wr_e0_d_done",   {31'd0, d_done}, 32'd0);
    @(negedge clk);
    check("wr_e1_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("wr_e1_d_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;

    // Table of accesses; writes also preload the fetch images.
    r_addr = 32'h3000 + $urandom_range(0, 32'hFFE);
    r_b1   = 8'($urandom_range(0, 255));
    r_b2   = 8'($urandom_range(0, 255));
    add_vec(2'd0, 32'h0000_0104, 8'h00, 32'h0000_00A5);
    add_vec(2'd0, 32'hABC2_0104, 8'h00, 32'h0000_00A5);
    add_vec(2'd1, 32'h0000_1000, 8'h13, 32'h0);
    add_vec(2'd1, 32'h0000_1001, 8'h05, 32'h0);
    add_vec(2'd1, 32'h0000_1002, 8'h00, 32'h0);
    add_vec(2'd1, 32'h0000_1003, 8'h00, 32'h0);
    add_vec(2'd1, 32'h0000_2000, 8'hEF, 32'h0);
    add_vec(2'd1, 32'h0000_2001, 8'hBE, 32'h0);
    add_vec(2'd1, 32'h0000_2002, 8'hAD, 32'h0);
    add_vec(2'd1, 32'h0000_2003, 8'hDE, 32'h0);
    add_vec(2'd1, 32'h0001_FFFE, 8'h11, 32'h0);
    add_vec(2'd1, 32'h0001_FFFF, 8'h22, 32'h0);
    add_vec(2'd1, 32'h0000_0000, 8'h33, 32'h0);
    add_vec(2'd1, 32'h0000_0001, 8'h44, 32'h0);
    add_vec(2'd2, 32'h0000_1000, 8'h00, 32'h0000_0513);
    add_vec(2'd2, 32'h0000_2000, 8'h00, 32'hDEAD_BEEF);
    add_vec(2'd1, r_addr,        r_b1,  32'h0);
    add_vec(2'd1, r_addr + 1,    r_b2,  32'h0);
    add_vec(2'd0, r_addr,        8'h00, {24'd0, r_b1});
    add_vec(2'd0, r_addr + 1,    8'h00, {24'd0, r_b2});
    add_vec(2'd0, 32'h0000_2003, 8'h00, 32'h0000_00DE);
    add_vec(2'd0, 32'h0000_0104, 8'h00, 32'h0000_00A5);
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // Fetch address stepping, including wrap past the top of RAM.
    fetch_trace(32'h0000_1000, 32'h0000_0513);
    fetch_trace(32'h0001_FFFE, 32'h4433_2211);

    // Priority: data read beats a simultaneous fetch.
    @(negedge clk);
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h104;
    i_req = 1'b1; i_addr = 32'h1000;
    exp_q.push_back({2'd0, 32'h0000_00A5});
    exp_q.push_back({2'd2, 32'h0000_0513});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("prio_d_done", {31'd0, d_done}, {31'd0, k == 3});
      check("prio_i_done", {31'd0, i_done}, {31'd0, k == 9});
      if (k == 4) check("prio_fetch_a", {15'd0, ram_a}, 32'h1000);
      if (k == 3) d_req = 1'b0;
      if (k == 9) i_req = 1'b0;
    end

    // Abort: drop i_req after E2.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h2000;
    repeat (3) @(negedge clk);
    i_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_i_done", {31'd0, i_done}, 32'd0);
    end
    check("abort_i_inst", i_inst, 32'h0000_0513);
    run_op(2'd0, 32'h0000_2001, 8'h00, 32'h0000_00BE);

    // Asynchronous reset at E3 of a fetch.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h2000;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ram_wr",   {31'd0, ram_wr}, 32'd0);
    check("rst_d_done",   {31'd0, d_done}, 32'd0);
    check("rst_i_done",   {31'd0, i_done}, 32'd0);
    check("rst_ram_a",    {15'd0, ram_a}, 32'd0);
    check("rst_d_rdata",  {24'd0, d_rdata}, 32'd0);
    check("rst_i_inst",   i_inst, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    i_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(2'd2, 32'h0000_2000, 8'h00, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-wide memory controller. It is the responder for the MEM stage's byte-request interface and for the IF stage's word-fetch interface. It arbitrates both requesters onto a single-port synchronous byte RAM and returns read bytes or assembled 32-bit instructions with one-cycle done pulses. It sits between the pipeline (mem, if) and the external RAM.

Parameters:
ADDR_W, 17, RAM address width; request addresses are truncated to [ADDR_W-1:0] and increment modulo 2^ADDR_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
d_req  in  1  data request from MEM stage, level
d_rw  in  1  0 = read, 1 = write
d_addr  in  32  data byte address
d_wdata  in  8  write byte
d_rdata  out  8  read byte, held until the next data read completes
d_done  out  1  one-cycle pulse: data access complete
i_req  in  1  fetch request from IF stage, level; deassertion aborts the fetch
i_addr  in  32  instruction base address
i_inst  out  32  assembled little-endian instruction, held until the next fetch completes
i_done  out  1  one-cycle pulse: fetch complete
ram_din  in  8  RAM read data, valid in the cycle after the RAM samples ram_a
ram_dout  out  8  RAM write data
ram_a  out  ADDR_W  RAM address
ram_wr  out  1  RAM write enable

Behaviour:
- All outputs are registered. Reset is async: all outputs are 0, state is IDLE, and outstanding accesses are discarded. The same applies on reset assertion mid-operation.
- The RAM samples ram_a, ram_wr and ram_dout at each rising edge; read data appears on ram_din during the following cycle.
- States: IDLE, D_ISSUE, D_CAPT, D_WR, I_FETCH.
- Requests are sampled only in IDLE. If both requests are pending, data wins. A fetch in progress is never preempted.
- The controller is IDLE during every done cycle. The requester must update or drop its request within that cycle; the next request is sampled at the following edge.
- Data read, request sampled at edge E0:
  - E0: ram_a <= d_addr[ADDR_W-1:0], ram_wr <= 0, go to D_ISSUE.
  - E1: go to D_CAPT.
  - E2: d_rdata <= ram_din, d_done <= 1, go to IDLE.
  - d_done is visible in the cycle after E2.
- Data write, request sampled at edge E0:
  - E0: ram_a <= d_addr, ram_dout <= d_wdata, ram_wr <= 1, go to D_WR.
  - E1: ram_wr <= 0, d_done <= 1, go to IDLE.
  - ram_wr is high for exactly one cycle.
- Fetch, request sampled at edge E0:
  - The base address is latched at E0.
  - Issue: ram_a = base, base+1, base+2, base+3 at edges E0..E3.
  - Capture: ram_din is captured at E2..E5 into bytes 0..3, with byte k going to i_inst[8k+7:8k].
  - E5: i_inst is updated and i_done <= 1. i_done is visible in the cycle after E5.
  - A 3-bit issue counter and a 3-bit capture counter track progress.
- Fetch abort: if i_req is sampled low at any edge E1..E5, go to IDLE at that edge.
  - No i_done is produced and i_inst is unchanged.
  - In-flight bytes are dropped.
- ram_wr is 0 in every state except D_WR. ram_a holds its last value while IDLE.
- d_done and i_done are never high in the same cycle.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> ram_wr, d_done, i_done, ram_a, d_rdata and i_inst become 0 immediately.
2. Write: d_req=1, d_rw=1, d_addr=0x00000104, d_wdata=0xA5 -> the cycle after E0 shows ram_wr=1, ram_a=0x104, ram_dout=0xA5. The cycle after E1 shows ram_wr=0, d_done=1.
3. Read-back: d_req=1, d_rw=0, d_addr=0x104 -> d_rdata=0xA5 with d_done=1 in the cycle after E2. ram_wr stays 0.
4. Fetch: i_req=1, i_addr=0x1000, RAM bytes 0x13,0x05,0x00,0x00 -> ram_a steps 0x1000..0x1003. i_inst=0x00000513 with i_done=1 in the cycle after E5. Wrap case: i_addr=0x1FFFE -> ram_a sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
5. Priority: d_req (read of 0x104) and i_req (0x1000) both asserted in IDLE -> data served first, with d_done=1. Fetch starts at the edge after the d_done cycle. i_done follows 6 edges later with i_inst=0x00000513.
6. Abort/reset mid-fetch: drop i_req after E2 -> IDLE, no i_done, i_inst keeps its prior value. Separately, assert rst at E3 -> all outputs 0, and a fresh fetch then completes normally.
